// File: rtl/eth_pcs_rx_gearbox.sv
// Purpose : re-frames a 32-bit PMA word stream into 66-bit PCS blocks, delivered as
//           two transfers (sync header + first 32 data bits, then remaining 32 bits).
// Latency : one register stage; no backpressure (one PMA word consumed every clock,
//           o_valid drops for one cycle whenever the buffer cannot supply a transfer).
//
// Ports:
//   i_clk        PCS receive clock
//   i_reset_n    asynchronous active-low reset
//   i_pma_data   PMA word, bit W_DATA-1 is the earliest received bit
//   i_slip       single-cycle request: discard the oldest bit, restart at transfer 0
//   o_valid      o_sync_data / o_data / o_trans_cnt valid this cycle
//   o_sync_data  block sync header (meaningful when o_trans_cnt == 0)
//   o_data       transfer data, bit W_DATA-1 is the earliest bit
//   o_trans_cnt  transfer index within the block (0 = header transfer)
//   o_block_lock block lock status
//
// Optional feature: define RX_BLOCK_LOCK_EN to include the cl.49 block lock FSM,
// which issues its own slips; otherwise o_block_lock is tied low.

module eth_pcs_rx_gearbox #(
  parameter int W_DATA = 32,
  parameter int W_SYNC = 2,
  parameter int W_BUF  = 96
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [W_DATA-1:0] i_pma_data,
  input  logic              i_slip,
  output logic              o_valid,
  output logic [W_SYNC-1:0] o_sync_data,
  output logic [W_DATA-1:0] o_data,
  output logic              o_trans_cnt,
  output logic              o_block_lock
);

  // Working window: buffered bits (MSB-aligned, oldest at the top) followed by the new word.
  localparam int W_AV  = W_BUF + W_DATA;
  localparam int W_HDR = W_DATA + W_SYNC;

  logic [W_BUF-1:0] buf_q, buf_d;
  logic [6:0]       lvl_q, lvl_d;
  logic             phase_q;

  logic [W_AV-1:0]  av;
  logic [W_AV-1:0]  rem;
  logic [7:0]       a_cnt;
  logic [7:0]       need;
  logic             ph;
  logic             take;
  logic             slip;

`ifdef RX_BLOCK_LOCK_EN
  typedef enum logic [2:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    VALID_SH,
    INVALID_SH,
    GOOD_64,
    SLIP
  } lock_state_t;

  lock_state_t      state_q, state_d;
  logic [6:0]       sh_cnt_q, sh_cnt_d;
  logic [4:0]       inv_cnt_q, inv_cnt_d;
  logic             lock_q, lock_d;
  // A header seen on the outputs is parked here until TEST_SH consumes it, so
  // headers arriving during the multi-cycle GOOD_64/RESET_CNT detour are not lost.
  logic             pend_q, pend_d;
  logic [W_SYNC-1:0] pend_sh_q, pend_sh_d;
  logic             slip_int;
  logic             hdr_evt;
  logic             sh_ok;

  assign hdr_evt = o_valid & ~o_trans_cnt;
  assign sh_ok   = ^pend_sh_q;

  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    lock_d    = lock_q;
    pend_d    = pend_q;
    pend_sh_d = pend_sh_q;
    slip_int  = 1'b0;

    case (state_q)
      LOCK_INIT: begin
        lock_d  = 1'b0;
        state_d = RESET_CNT;
      end
      RESET_CNT: begin
        sh_cnt_d  = '0;
        inv_cnt_d = '0;
        state_d   = TEST_SH;
      end
      TEST_SH: begin
        if (pend_q) begin
          pend_d    = 1'b0;
          sh_cnt_d  = sh_cnt_q + 7'd1;
          inv_cnt_d = inv_cnt_q + {4'd0, ~sh_ok};
          state_d   = sh_ok ? VALID_SH : INVALID_SH;
        end
      end
      VALID_SH: begin
        if (sh_cnt_q == 7'd64) state_d = (inv_cnt_q == 5'd0) ? GOOD_64 : RESET_CNT;
        else                   state_d = TEST_SH;
      end
      INVALID_SH: begin
        if (inv_cnt_q == 5'd16 || !lock_q) state_d = SLIP;
        else if (sh_cnt_q == 7'd64)        state_d = RESET_CNT;
        else                               state_d = TEST_SH;
      end
      GOOD_64: begin
        lock_d  = 1'b1;
        state_d = RESET_CNT;
      end
      SLIP: begin
        lock_d   = 1'b0;
        slip_int = 1'b1;
        state_d  = RESET_CNT;
      end
      default: state_d = LOCK_INIT;
    endcase

    if (hdr_evt) begin
      pend_d    = 1'b1;
      pend_sh_d = o_sync_data;
    end
    // Headers still in flight belong to the old alignment once a slip is issued.
    if (state_q == SLIP) pend_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= LOCK_INIT;
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
      lock_q    <= 1'b0;
      pend_q    <= 1'b0;
      pend_sh_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      lock_q    <= lock_d;
      pend_q    <= pend_d;
      pend_sh_q <= pend_sh_d;
    end
  end

  assign slip         = i_slip | slip_int;
  assign o_block_lock = lock_q;
`else
  assign slip         = i_slip;
  assign o_block_lock = 1'b0;
`endif

  // Bits below the fill level are always zero, so the new word can simply be OR-ed in.
  always_comb begin
    av    = {buf_q, {W_DATA{1'b0}}} | ({i_pma_data, {W_BUF{1'b0}}} >> lvl_q);
    a_cnt = {1'b0, lvl_q} + 8'(W_DATA);
    ph    = phase_q;
    if (slip) begin
      av    = av << 1;
      a_cnt = a_cnt - 8'd1;
      ph    = 1'b0;
    end
    need  = ph ? 8'(W_DATA) : 8'(W_HDR);
    take  = (a_cnt >= need);
    rem   = ph ? (av << W_DATA) : (av << W_HDR);
    if (take) begin
      buf_d = W_BUF'(rem >> W_DATA);
      lvl_d = 7'(a_cnt - need);
    end else begin
      buf_d = W_BUF'(av >> W_DATA);
      lvl_d = 7'(a_cnt);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      buf_q       <= '0;
      lvl_q       <= '0;
      phase_q     <= 1'b0;
      o_valid     <= 1'b0;
      o_sync_data <= '0;
      o_data      <= '0;
      o_trans_cnt <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      lvl_q   <= lvl_d;
      o_valid <= take;
      if (take) begin
        phase_q     <= ~ph;
        o_trans_cnt <= ph;
        if (!ph) begin
          o_sync_data <= av[W_AV-1 -: W_SYNC];
          o_data      <= av[W_AV-1-W_SYNC -: W_DATA];
        end else begin
          o_data      <= av[W_AV-1 -: W_DATA];
        end
      end else begin
        phase_q <= ph;
      end
    end
  end

endmodule

// File: doc/eth_pcs_rx_gearbox.md
Name: eth_pcs_rx_gearbox

Overview:
- Receive-side counterpart of the PCS TX gearbox.
- Takes one 32-bit PMA word per clock and re-frames the serial stream into 66-bit PCS blocks.
- Each block is delivered as two transfers: transfer 0 carries the 2-bit sync header plus data bits 31..0; transfer 1 carries the remaining 32 data bits.
- Sits between the PMA receive interface and the descrambler/block-lock logic; supports bit slip for block alignment.

Parameters:
- W_DATA, 32, PMA word and per-transfer data width.
- W_SYNC, 2, sync header width.
- W_BUF, 96, internal bit buffer depth; must be >= 2*W_DATA+W_SYNC.

Ports:
- i_clk  in  1  PCS receive clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_pma_data  in  W_DATA  PMA word. Bit 31 is the earliest received bit.
- i_slip  in  1  single-cycle request to discard one bit and restart at transfer 0.
- o_valid  out  1  o_sync_data/o_data valid this cycle.
- o_sync_data  out  W_SYNC  header of current block; meaningful only when o_trans_cnt==0.
- o_data  out  W_DATA  block data; bit 31 is the earliest bit.
- o_trans_cnt  out  1  transfer index within block (0 = header transfer).
- o_block_lock  out  1  block lock status (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_sync_data=0, o_data=0, o_trans_cnt=0, o_block_lock=0; buffer level L=0; phase=0.
- Stream order: a block is sync[1], sync[0], data[31]..data[0] of transfer 0, then data[31]..data[0] of transfer 1. This is the exact inverse of the TX gearbox mapping.
- i_pma_data is consumed every clock and has no valid qualifier. Each cycle:
  - Available bits A = L + 32 (buffered bits followed by i_pma_data).
  - If i_slip=1: drop the oldest available bit (A -= 1) and force phase=0 before the need check.
  - Need N = 34 if phase==0, else 32.
  - If A >= N: register the oldest N bits to the outputs (header = first 2 bits when phase 0), assert o_valid, set o_trans_cnt to the current phase, toggle phase, L = A - N.
  - Else: o_valid=0, outputs hold their last value, phase unchanged, L = A.
- Latency: one register stage; a bit that arrives on i_pma_data appears on the outputs at the next edge at the earliest.
- Steady state with no slip: from reset, the first o_valid occurs at the 2nd edge; thereafter o_valid is high 32 of every 33 cycles (16 blocks per 33 words). The low cycle occurs exactly when A < N.
- Bound: L never exceeds 65. A slip only reduces occupancy, so no overflow is possible. L is 7 bits wide.
- Slip in a stall cycle: the bit is still discarded and phase forced to 0.
- Slip while phase==1: the half-delivered block is abandoned; the next valid transfer has o_trans_cnt=0.
- Consecutive slips on back-to-back cycles: each discards one bit.
- Reset mid-stream clears all buffered bits immediately; no partial block is emitted after release.

Optional Feature:
- Macro RX_BLOCK_LOCK_EN.
- When defined, an IEEE 802.3 cl.49 lock FSM is included with states LOCK_INIT, RESET_CNT, TEST_SH, VALID_SH, INVALID_SH, GOOD_64, SLIP.
  - It evaluates o_sync_data on each o_valid with o_trans_cnt==0; a header is valid iff it is 01 or 10.
  - Unlocked: 64 consecutive valid headers -> o_block_lock=1. Any invalid header -> internal slip, counters cleared.
  - Locked: 16 invalid headers within a 64-header window -> o_block_lock=0 plus an internal slip. A window of 64 with <16 invalid restarts the window.
  - The internal slip is OR-ed with i_slip and takes effect on the cycle after detection.
- When not defined: no FSM, o_block_lock is tied to 0, and only i_slip causes slips.

Test Plan:
- Reset, constant i_pma_data=32'hAAAAAAAA -> o_valid first high on the 2nd edge with o_sync_data=2'b10, o_data=32'hAAAAAAAA, o_trans_cnt=0; next transfer o_trans_cnt=1, o_data=32'hAAAAAAAA.
- Feed TX gearbox output for 16 known blocks (header 01, data incrementing from 64'h0) -> 16 blocks recovered bit-exact; exactly one o_valid=0 cycle per 33 input cycles.
- Aligned stream pre-delayed by 5 bits, pulse i_slip 5 times on non-consecutive cycles -> subsequent blocks bit-exact, first post-slip transfer has o_trans_cnt=0.
- i_slip asserted while phase==1 -> next o_valid transfer has o_trans_cnt=0 and the abandoned block is never completed.
- Assert i_reset_n=0 mid-block for 1 cycle asynchronously -> all outputs 0 immediately; after release the first o_valid again occurs on the 2nd edge.
- With RX_BLOCK_LOCK_EN: misaligned stream by 17 bits -> automatic slips; o_block_lock=1 after 64 consecutive valid headers. Then inject 16 headers of 2'b00 within 64 -> o_block_lock=0 and a slip is issued.
